// File: rtl/ysyx_24100005_ifu_if.sv
// ysyx_24100005_ifu_if
// Bundles every handshake/bus signal of the instruction fetch unit:
//   imem request  : imem_req_valid/imem_req_ready/imem_req_addr
//   imem response : imem_resp_valid/imem_resp_data/imem_resp_err
//   fetch output  : out_valid/out_ready/out_pc/out_inst/out_fault
//   redirect      : redirect_valid/redirect_pc
// master = IFU side, slave = memory + consumer + redirect source side.
interface ysyx_24100005_ifu_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst, out_fault,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
               out_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst, out_fault,
        output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
               out_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_24100005_ifu.sv
// ysyx_24100005_ifu
// Instruction fetch unit: owns the PC, issues one word-aligned read per
// instruction (at most one outstanding), and presents the fetched word with
// its PC downstream. A redirect overrides the sequential PC and kills any
// in-flight fetch.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-low reset
//   bus  - ysyx_24100005_ifu_if.master (imem req/resp, output, redirect)
module ysyx_24100005_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    ysyx_24100005_ifu_if.master      bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

    state_e      fsm_q, fsm_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        fault_q, fault_d;
    logic        kill_q, kill_d;   // response of the in-flight request must be dropped

    logic req_hs;
    assign req_hs = (fsm_q == REQ) && bus.imem_req_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            fault_q <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        kill_d  = kill_q;

        if (bus.redirect_valid) begin
            // Redirect wins over everything; a response arriving in the same
            // cycle belongs to the old path and is never latched.
            pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
            unique case (fsm_q)
                IDLE: fsm_d = REQ;
                REQ: begin
                    if (req_hs) begin
                        fsm_d  = WAIT;
                        kill_d = 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.imem_resp_valid) begin
                        fsm_d  = REQ;
                        kill_d = 1'b0;
                    end else begin
                        kill_d = 1'b1;
                    end
                end
                HOLD: fsm_d = REQ;
                default: fsm_d = IDLE;
            endcase
        end else begin
            unique case (fsm_q)
                IDLE: fsm_d = REQ;
                REQ: begin
                    if (req_hs) begin
                        fsm_d  = WAIT;
                        kill_d = 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.imem_resp_valid) begin
                        if (kill_q) begin
                            // Drain the stale response, then fetch the redirect target.
                            fsm_d  = REQ;
                            kill_d = 1'b0;
                        end else begin
                            inst_d  = bus.imem_resp_data;
                            fault_d = bus.imem_resp_err;
                            fsm_d   = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        pc_d  = pc_q + 32'd4;   // wraps naturally at 2^32
                        fsm_d = REQ;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    assign bus.imem_req_valid = (fsm_q == REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.out_valid      = (fsm_q == HOLD);
    assign bus.out_pc         = pc_q;
    assign bus.out_inst       = inst_q;
    assign bus.out_fault      = fault_q;
endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
module tb_ysyx_24100005_ifu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_24100005_ifu_if bus ();

    ysyx_24100005_ifu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;       // expected request address == expected out_pc
        logic [31:0] data;       // memory word returned == expected out_inst
        logic        err;        // memory fault == expected out_fault
        int          ready_dly;  // cycles imem_req_ready held low
        int          hold_dly;   // cycles out_ready held low in HOLD
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full fetch: optional ready stall, 1-cycle response, optional HOLD stall.
    task automatic do_fetch(input vec_t v);
        int n = 0;
        while (bus.imem_req_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_valid_seen", {31'b0, bus.imem_req_valid}, 32'h1);
        chk("req_addr", bus.imem_req_addr, v.addr);
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < v.ready_dly; i++) begin
            tick();
            chk("req_valid_stall", {31'b0, bus.imem_req_valid}, 32'h1);
            chk("req_addr_stall", bus.imem_req_addr, v.addr);
        end
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        chk("wait_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        chk("wait_out_valid", {31'b0, bus.out_valid}, 32'h0);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = v.data;
        bus.imem_resp_err   = v.err;
        tick();
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.imem_resp_err   = 1'b0;
        for (int i = 0; i <= v.hold_dly; i++) begin
            chk("out_valid", {31'b0, bus.out_valid}, 32'h1);
            chk("out_pc", bus.out_pc, v.addr);
            chk("out_inst", bus.out_inst, v.data);
            chk("out_fault", {31'b0, bus.out_fault}, {31'b0, v.err});
            chk("hold_no_req", {31'b0, bus.imem_req_valid}, 32'h0);
            bus.out_ready = (i == v.hold_dly);
            tick();
        end
        bus.out_ready = 1'b0;
        // Back-to-back: the very next cycle is a new request at pc+4.
        chk("next_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
        chk("next_req_addr", bus.imem_req_addr, v.addr + 32'd4);
        $display("fetch pc=%08h inst=%08h fault=%0b", v.addr, v.data, v.err);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h8000_0000);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("rst_out_pc", bus.out_pc, 32'h8000_0000);
        chk("rst_out_inst", bus.out_inst, 32'h0);
        chk("rst_out_fault", {31'b0, bus.out_fault}, 32'h0);
    endtask

    initial begin
        vecs[0] = '{32'h8000_0000, 32'h0000_0013, 1'b0, 0, 5};
        vecs[1] = '{32'h8000_0004, 32'h0010_0093, 1'b0, 4, 0};
        vecs[2] = '{32'h8000_0008, 32'h0BAD_C0DE, 1'b1, 0, 0};
        vecs[3] = '{32'h8000_000C, 32'h0000_0073, 1'b0, 0, 0};
        vecs[4] = '{32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 0, 0};
        vecs[5] = '{32'h0000_0000, 32'h8765_4321, 1'b0, 0, 0};

        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.imem_resp_err   = 1'b0;
        bus.out_ready       = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;

        // Reset and first request timing.
        repeat (3) tick();
        chk_reset_outputs();
        rst = 1'b1;
        #1;
        chk("idle_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        tick();
        chk("first_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);

        // Sequential fetches: stalls, fault, fault clear.
        for (int k = 0; k < 4; k++) do_fetch(vecs[k]);

        // Redirect during WAIT, stale response two cycles later.
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0103;
        tick();
        bus.redirect_valid = 1'b0;
        chk("killwait_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        tick();
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        bus.imem_resp_valid = 1'b0;
        chk("drop_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("drop_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
        chk("drop_req_addr", bus.imem_req_addr, 32'h8000_0100);
        $display("redirect in WAIT -> next req %08h", bus.imem_req_addr);

        // Redirect same cycle as request handshake.
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0300;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("hsredir_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        bus.imem_resp_valid = 1'b0;
        chk("hsredir_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("hsredir_req_addr", bus.imem_req_addr, 32'h8000_0300);
        $display("redirect at handshake -> next req %08h", bus.imem_req_addr);

        // Redirect same cycle as response in WAIT.
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready  = 1'b0;
        bus.redirect_valid  = 1'b1;
        bus.redirect_pc     = 32'h8000_0400;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        bus.redirect_valid  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        chk("respredir_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("respredir_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
        chk("respredir_req_addr", bus.imem_req_addr, 32'h8000_0400);
        $display("redirect with response -> next req %08h", bus.imem_req_addr);

        // Redirect in HOLD together with out_ready: redirect target, not pc+4.
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h0000_0493;
        tick();
        bus.imem_resp_valid = 1'b0;
        chk("holdredir_out_pc", bus.out_pc, 32'h8000_0400);
        chk("holdredir_out_inst", bus.out_inst, 32'h0000_0493);
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0200;
        tick();
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("holdredir_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
        chk("holdredir_req_addr", bus.imem_req_addr, 32'h8000_0200);
        $display("redirect in HOLD -> next req %08h", bus.imem_req_addr);

        // Redirect in REQ without handshake: address changes, low bits forced 0.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_050F;
        tick();
        chk("reqredir_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
        chk("reqredir_req_addr", bus.imem_req_addr, 32'h8000_050C);
        bus.redirect_pc = 32'hFFFF_FFFE;
        tick();
        bus.redirect_valid = 1'b0;
        chk("wrapredir_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);

        // PC wrap: 0xFFFF_FFFC consumed -> next request at 0.
        do_fetch(vecs[4]);
        do_fetch(vecs[5]);

        // Reset asserted mid-WAIT discards the transaction.
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk_reset_outputs();
        tick();
        rst = 1'b1;
        tick();
        chk("rerst_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
        chk("rerst_req_addr", bus.imem_req_addr, 32'h8000_0000);
        $display("reset mid-WAIT -> req %08h", bus.imem_req_addr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
